// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encodings used by both
//                uart_tx and uart_rx, bit-timing helpers, parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Frame-level FSM states, common to transmitter and receiver
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clocks per bit period (integer divide; callers guarantee result >= 2)
    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width of a counter that must hold 0..cpb-1
    function automatic int cnt_width(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

    // Counter width for the default 50 MHz / 9600 baud configuration
    localparam int DEFAULT_CPB   = cycles_per_bit(50_000_000, 9_600);
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_CPB);

    // sel=1 -> even-sum parity bit (^data); sel=0 -> its complement
    function automatic logic parity_bit(input logic [7:0] data, input logic sel);
        return sel ? (^data) : ~(^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter. Counts 0..p_cpb-1 and flags the last
//                cycle of each bit period; held at zero while clear_i is high.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int p_cpb = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int                CNT_W  = cnt_width(p_cpb);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(p_cpb - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_end_o = (count_q == C_LAST);

    // Next count: wrap at end of bit, hold at zero while cleared
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || bit_end_o) begin
            count_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8-bit UART transmitter. One byte per valid/ready handshake,
//                start bit, 8 data bits LSB first, optional parity, 1 or 2
//                stop bits. tx_o is registered and idles high.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int p_clk_speed_hz = 50_000_000,
    parameter int p_baud_rate    = 9_600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       parity_en_i,
    input  logic       parity_sel_i,
    input  logic       stop_bits_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CPB = cycles_per_bit(p_clk_speed_hz, p_baud_rate);

    logic [2:0] state_q,      state_d;
    logic [7:0] shift_q,      shift_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic       parity_en_q,  parity_en_d;
    logic       parity_bit_q, parity_bit_d;
    logic       stop2_q,      stop2_d;
    logic       stop_cnt_q,   stop_cnt_d;
    logic       tx_q,         tx_d;
    logic       done_q,       done_d;

    logic       w_bit_end;
    logic       w_accept;
    logic       w_idle;

    assign w_idle   = (state_q == ST_IDLE);
    assign ready_o  = w_idle && enable_i;
    assign w_accept = valid_i && ready_o;
    assign tx_o     = tx_q;
    assign busy_o   = !w_idle;
    assign done_o   = done_q;

    // Bit timer is held at zero between frames so the start bit gets a full period
    uart_baud_cnt #(
        .p_cpb     (CPB)
    ) u_baud_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_idle),
        .bit_end_o (w_bit_end)
    );

    // Frame sequencing; tx_d is the line level for the cycle after this edge
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_en_d  = parity_en_q;
        parity_bit_d = parity_bit_q;
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt_q;
        tx_d         = tx_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_accept) begin
                    // Snapshot byte and line format; later input changes are ignored
                    shift_d      = data_i;
                    parity_en_d  = parity_en_i;
                    parity_bit_d = parity_bit(data_i, parity_sel_i);
                    stop2_d      = stop_bits_i;
                    bit_cnt_d    = 3'd0;
                    stop_cnt_d   = 1'b0;
                    tx_d         = 1'b0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        stop_cnt_d = 1'b0;
                        if (parity_en_q) begin
                            tx_d    = parity_bit_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (w_bit_end) begin
                    if (stop_cnt_q == stop2_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                // Unused encodings recover straight to idle with the line high
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_en_q  <= parity_en_d;
            parity_bit_q <= parity_bit_d;
            stop2_q      <= stop2_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (CPB = 10). A frame-level
//                model predicts tx/busy/done/ready every cycle; directed
//                scenarios add literal expectations on line waveforms.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 10;
    localparam int CAP_N  = 130;

    logic       clk = 1'b0;
    logic       rst, en, valid, pe, ps, sb;
    logic [7:0] data;
    logic       ready, tx, busy, done;

    uart_tx #(
        .p_clk_speed_hz (CLK_HZ),
        .p_baud_rate    (BAUD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .data_i       (data),
        .valid_i      (valid),
        .ready_o      (ready),
        .parity_en_i  (pe),
        .parity_sel_i (ps),
        .stop_bits_i  (sb),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame is a list of line levels, one per bit period; m_pos counts
    // cycles into it (-1 when no frame is being sent).
    bit m_bits[16];
    int m_len = 0;
    int m_pos = -1;
    bit m_done = 0;
    int m_acc = 0;

    initial begin
        forever begin
            @(posedge clk);
            m_done = 0;
            if (rst) begin
                m_pos = -1;
            end else if (m_pos < 0) begin
                if (en && valid) begin
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_bits[1+i] = data[i];
                    m_len = 9;
                    if (pe) begin
                        m_bits[m_len] = ps ? (^data) : !(^data);
                        m_len++;
                    end
                    m_bits[m_len] = 1'b1; m_len++;
                    if (sb) begin m_bits[m_len] = 1'b1; m_len++; end
                    m_pos = 0;
                    m_acc++;
                end
            end else begin
                m_pos++;
                if (m_pos == m_len * CPB) begin
                    m_pos  = -1;
                    m_done = 1;
                end
            end
            #1;
            check("tx",    int'(tx),    (m_pos < 0) ? 1 : int'(m_bits[m_pos / CPB]));
            check("busy",  int'(busy),  int'(m_pos >= 0));
            check("done",  int'(done),  int'(m_done));
            check("ready", int'(ready), int'((m_pos < 0) && en));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer a byte until it is accepted; returns #1 after the accept edge.
    task automatic push(input logic [7:0] d, input bit p_en, input bit p_sel,
                        input bit s2, input bit rnd_en);
        bit ok = 0;
        @(negedge clk);
        data = d; pe = p_en; ps = p_sel; sb = s2; valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (rnd_en) en = ($urandom_range(0, 3) != 0);
            #1;
            if (ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        en    = 1'b1;
    endtask

    bit cap_tx[CAP_N];
    bit cap_done[CAP_N];

    // Record line and done for CAP_N cycles, index 0 = first cycle after accept
    task automatic capture();
        for (int k = 0; k < CAP_N; k++) begin
            cap_tx[k]   = tx;
            cap_done[k] = done;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int first_done();
        for (int k = 0; k < CAP_N; k++) if (cap_done[k]) return k;
        return -1;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit   exp_a5[10];
        int   acc0;
        time  t1, t2;
        bit   seen_done;

        rst = 1'b1; en = 1'b1; valid = 1'b0;
        data = 8'h00; pe = 1'b0; ps = 1'b0; sb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (50) @(negedge clk);
        check("idle_tx", int'(tx), 1);
        check("idle_ready", int'(ready), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);

        // 0xA5, no parity, one stop bit
        exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        push(8'hA5, 0, 0, 0, 0);
        capture();
        for (int b = 0; b < 10; b++) check($sformatf("a5_bit%0d", b), int'(cap_tx[5 + 10*b]), int'(exp_a5[b]));
        check("a5_first_low", int'(cap_tx[0]), 0);
        check("a5_done_at", first_done(), 100);
        check("a5_done_width", int'(cap_done[101]), 0);

        // 0x03 with parity sel=1 and two stop bits
        push(8'h03, 1, 1, 1, 0);
        capture();
        check("p03_sel1_parity", int'(cap_tx[95]), 0);
        check("p03_sel1_stop2", int'(cap_tx[115]), 1);
        check("p03_sel1_len", first_done(), 120);

        // 0x03 with parity sel=0 and two stop bits
        push(8'h03, 1, 0, 1, 0);
        capture();
        check("p03_sel0_parity", int'(cap_tx[95]), 1);
        check("p03_sel0_len", first_done(), 120);

        // Back-to-back: valid held, second byte waits only for the done cycle
        acc0 = m_acc;
        @(negedge clk);
        data = 8'h55; pe = 0; ps = 0; sb = 0; valid = 1'b1;
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        @(posedge clk); t1 = $time;
        #1 data = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        @(posedge clk); t2 = $time;
        #1 valid = 1'b0;
        check("b2b_gap_cycles", int'((t2 - t1) / 10), 101);
        repeat (110) @(negedge clk);
        check("b2b_accepts", m_acc - acc0, 2);

        // Mid-frame input changes and enable drop leave the frame intact
        acc0 = m_acc;
        push(8'h3C, 0, 0, 0, 0);
        repeat (30) @(negedge clk);
        data = 8'h00; pe = 1'b1; ps = 1'b1; sb = 1'b1; en = 1'b0; valid = 1'b1;
        repeat (100) @(negedge clk);
        check("en_low_busy", int'(busy), 0);
        check("en_low_ready", int'(ready), 0);
        check("en_low_accepts", m_acc - acc0, 1);
        valid = 1'b0; en = 1'b1; pe = 1'b0; sb = 1'b0;

        // Reset pulse during data bit 3 (line low for 0xF7)
        push(8'hF7, 0, 0, 0, 0);
        repeat (44) @(posedge clk);
        #1;
        check("pre_rst_tx", int'(tx), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        seen_done = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("rst_no_done", int'(seen_done), 0);

        // All 256 byte values with random format, gaps and enable toggling
        for (int b = 0; b < 256; b++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(8'(b), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 60)) @(negedge clk);
                data = 8'($urandom); pe = 1'($urandom); ps = 1'($urandom);
                sb = 1'($urandom); en = 1'($urandom);
                repeat ($urandom_range(1, 20)) @(negedge clk);
                en = 1'b1;
            end
        end
        repeat (150) @(negedge clk);
        check("random_accepts_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
